// File: rtl/down_counter_ctl.sv
// Presettable down counter slice with one-shot, auto-reload and free-run modes.
// State updates on the falling clock edge; bo cascades into the next slice's en.
module down_counter_ctl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] M_ONESHOT = 2'b00;
    localparam logic [1:0] M_RELOAD  = 2'b01;
    localparam logic [1:0] M_FREERUN = 2'b10;

    state_t           state;
    logic [WIDTH-1:0] rld;
    logic [1:0]       mreg;

    // The reserved encoding behaves as one-shot, so it is folded at load time.
    function automatic logic [1:0] fold_mode(input logic [1:0] m);
        return (m == 2'b11) ? M_ONESHOT : m;
    endfunction

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            q     <= '0;
            rld   <= '0;
            mreg  <= M_ONESHOT;
            tc    <= 1'b0;
            state <= IDLE;
        end else begin
            tc <= 1'b0;
            if (load) begin
                q     <= din;
                rld   <= din;
                mreg  <= fold_mode(mode);
                state <= RUN;
            end else if (state == RUN && en) begin
                if (q != '0) begin
                    q <= q - WIDTH'(1);
                end else begin
                    // Expiry edge: pulse tc and pick the follow-on count by mode.
                    tc <= 1'b1;
                    case (mreg)
                        M_RELOAD:  q <= rld;
                        M_FREERUN: q <= '1;
                        default:   state <= DONE;
                    endcase
                end
            end
        end
    end

    assign bo   = en & (state == RUN) & (q == '0);
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter_ctl.sv
// Randomized and directed bench for down_counter_ctl against an arithmetic timer model,
// plus a two-slice cascade built from bo -> en.
module tb_down_counter_ctl;

    localparam int W = 4;

    logic         clk, clr, en, load;
    logic [W-1:0] din;
    logic [1:0]   mode;
    logic [W-1:0] q;
    logic         tc, bo, busy, done;

    logic         c_load, c_en;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_tc, lo_bo, lo_busy, lo_done;
    logic         hi_tc, hi_bo, hi_busy, hi_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, 0 idle / 1 running / 2 finished
    int m_q, m_rld, m_mode, m_st, m_tc;

    down_counter_ctl #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .din(din), .mode(mode),
        .q(q), .tc(tc), .bo(bo), .busy(busy), .done(done)
    );

    down_counter_ctl #(.WIDTH(W)) u_lo (
        .clk(clk), .clr(clr), .en(c_en), .load(c_load), .din(4'h2), .mode(2'b10),
        .q(lo_q), .tc(lo_tc), .bo(lo_bo), .busy(lo_busy), .done(lo_done)
    );

    down_counter_ctl #(.WIDTH(W)) u_hi (
        .clk(clk), .clr(clr), .en(lo_bo), .load(c_load), .din(4'h1), .mode(2'b00),
        .q(hi_q), .tc(hi_tc), .bo(hi_bo), .busy(hi_busy), .done(hi_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_rld = 0; m_mode = 0; m_st = 0; m_tc = 0;
    endtask

    task automatic model_step(input int ld, input int e, input int d, input int md);
        m_tc = 0;
        if (ld != 0) begin
            m_q = d; m_rld = d; m_mode = (md == 3) ? 0 : md; m_st = 1;
        end else if (m_st == 1 && e != 0) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
                m_tc = 1;
                if (m_mode == 1)      m_q = m_rld;
                else if (m_mode == 2) m_q = (1 << W) - 1;
                else                  m_st = 2;
            end
        end
    endtask

    // Drive at the rising edge, check bo before the falling edge, check state after it.
    task automatic cycle(input logic ld, input logic e, input logic [W-1:0] d, input logic [1:0] md);
        load = ld; en = e; din = d; mode = md;
        #1;
        check("bo", int'(bo), (e && m_st == 1 && m_q == 0) ? 1 : 0);
        @(negedge clk);
        model_step(int'(ld), int'(e), int'(d), int'(md));
        @(posedge clk);
        check("q", int'(q), m_q);
        check("tc", int'(tc), m_tc);
        check("busy", int'(busy), (m_st == 1) ? 1 : 0);
        check("done", int'(done), (m_st == 2) ? 1 : 0);
    endtask

    initial begin
        clr = 1'b0; load = 1'b1; en = 1'b1; din = 4'd5; mode = 2'b00;
        c_load = 1'b0; c_en = 1'b0;
        model_reset();

        // Reset held over several falling edges with load asserted
        repeat (3) @(negedge clk);
        @(posedge clk);
        check("rst_q", int'(q), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bo", int'(bo), 0);
        #2;
        clr = 1'b1; load = 1'b0;
        #1;
        check("rel_q", int'(q), 0);
        check("rel_busy", int'(busy), 0);
        @(posedge clk);

        // One-shot from 3
        cycle(1, 0, 4'd3, 2'b00);
        check("os_load_q", int'(q), 3);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 1, 4'd0, 2'b00);
            check("os_q", int'(q), 3 - i);
        end
        cycle(0, 1, 4'd0, 2'b00);
        check("os_tc", int'(tc), 1);
        check("os_done", int'(done), 1);
        repeat (3) cycle(0, 1, 4'd0, 2'b00);
        check("os_hold_q", int'(q), 0);

        // Auto-reload from 2
        cycle(1, 0, 4'd2, 2'b01);
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 1, 4'd0, 2'b00);
            check("ar_tc", int'(tc), (i % 3 == 0) ? 1 : 0);
        end

        // Free-run wrap from 1
        cycle(1, 0, 4'd1, 2'b10);
        cycle(0, 1, 4'd0, 2'b00);
        cycle(0, 1, 4'd0, 2'b00);
        check("fr_wrap_q", int'(q), 15);
        check("fr_wrap_tc", int'(tc), 1);
        cycle(0, 1, 4'd0, 2'b00);
        check("fr_q14", int'(q), 14);

        // Load colliding with expiry, then hold with en low
        cycle(1, 0, 4'd0, 2'b00);
        cycle(1, 1, 4'd7, 2'b00);
        check("col_q", int'(q), 7);
        check("col_tc", int'(tc), 0);
        repeat (5) cycle(0, 0, 4'd0, 2'b00);
        check("hold_q", int'(q), 7);

        // Reserved mode behaves as one-shot; mode changes in RUN are ignored
        cycle(1, 0, 4'd1, 2'b11);
        repeat (3) cycle(0, 1, 4'd0, 2'b01);
        check("rsv_done", int'(done), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom), 2'($urandom));
        end

        // Async abort while tc is high
        cycle(1, 0, 4'd0, 2'b01);
        cycle(0, 1, 4'd0, 2'b00);
        check("ab_tc_pre", int'(tc), 1);
        cycle(1, 0, 4'd9, 2'b10);
        cycle(0, 1, 4'd0, 2'b00);
        cycle(1, 0, 4'd0, 2'b01);
        cycle(0, 1, 4'd0, 2'b00);
        #2;
        clr = 1'b0;
        #1;
        check("ab_q", int'(q), 0);
        check("ab_tc", int'(tc), 0);
        check("ab_busy", int'(busy), 0);
        model_reset();
        @(posedge clk);
        #2;
        clr = 1'b1;
        @(posedge clk);

        // Mid-count abort with a nonzero count
        cycle(1, 0, 4'd12, 2'b00);
        cycle(0, 1, 4'd0, 2'b00);
        #2;
        clr = 1'b0;
        #1;
        check("ab2_q", int'(q), 0);
        model_reset();
        @(posedge clk);
        #2;
        clr = 1'b1;
        load = 1'b0; en = 1'b0;
        @(posedge clk);

        // Two-slice cascade counting 0x12 down
        c_load = 1'b1;
        @(negedge clk);
        @(posedge clk);
        c_load = 1'b0;
        check("cas_load", int'({hi_q, lo_q}), 18);
        c_en = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            @(posedge clk);
            if (k <= 18) check("cas_q", int'({hi_q, lo_q}), 18 - k);
            check("cas_hi_tc", int'(hi_tc), (k == 19) ? 1 : 0);
        end
        check("cas_hi_done", int'(hi_done), 1);
        c_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
